interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Cycle-level controller that takes over the tinymos6502 datapath for the reset, NMI, IRQ and BRK sequences. It arbitrates between the pending interrupt sources and drives the register enables for the PCH/PCL/processor-status pushes. It also drives the stack-pointer decrement, the vector fetch into PCL/PCH and the RW line. It sits beside the instruction decoder. While `busy` is high, its enables replace the decoder's enables.

## Interface
Parameters:
- `VEC_NMI`, 16'hFFFA, NMI vector low-byte address
- `VEC_RST`, 16'hFFFC, reset vector low-byte address
- `VEC_IRQ`, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RST_N`  in  1  reset, synchronous, active-low
- `RDY`  in  1  high = proceed; low stalls read cycles
- `IRQ`  in  1  active-low level interrupt request
- `NMI`  in  1  active-low, falling-edge triggered
- `i_flag`  in  1  interrupt-disable bit from the status register
- `insn_done`  in  1  decoder: last cycle of the current instruction
- `brk_req`  in  1  decoder: BRK opcode decoded (single-cycle pulse)
- `busy`  out  1  sequencer owns the datapath
- `rw`  out  1  1 = read, 0 = write
- `addr_src`  out  2  address source: 0 = PC, 1 = stack (0x01,SP), 2 = `vec_addr`
- `vec_addr`  out  16  vector fetch address
- `pcho`, `pclo`, `psro`  out  1 each  drive PCH, PCL or the status register onto the data bus
- `pchi`, `pcli`  out  1 each  load PCH or PCL from the data bus
- `sp_dec`  out  1  decrement the stack pointer
- `b_flag`  out  1  value of the B bit in the pushed status byte
- `set_i`  out  1  set the interrupt-disable flag
- `int_kind`  out  2  0 = RST, 1 = NMI, 2 = IRQ, 3 = BRK

## Operation
- States: `RST_HOLD`, `IDLE`, `T1`..`T6`.
- **Reset.** When `RST_N`=0 at a clock edge, the next state is `RST_HOLD` from any state, including mid-sequence.
  - `RST_HOLD` outputs: `busy`=1, `rw`=1, `addr_src`=0, `vec_addr`=0, `int_kind`=RST. All enables, `sp_dec`, `b_flag` and `set_i` are 0.
  - The NMI latch is cleared.
  - The first edge with `RST_N`=1 moves to `T1` with `int_kind`=RST.
- **Start arbitration** (in `IDLE`), priority order:
  - NMI latch set and `insn_done` → NMI.
  - `brk_req` → BRK. BRK does not wait for `insn_done`.
  - `insn_done` & !`IRQ` & !`i_flag` → IRQ.
  - Otherwise stay in `IDLE` with `busy`=0 and all outputs at their `RST_HOLD` values except `busy`.
  - On start, the next state is `T1`. An IRQ with `i_flag`=1 is ignored. IRQ is level-sensitive and is not latched.
- **NMI latch.**
  - Set on the cycle after `NMI` is sampled 1 then 0 (registered falling-edge detect).
  - Cleared on entry to `T5` of any NMI-vectored sequence.
  - A new edge arriving in the same cycle as the clear wins, so the latch stays set.
- **Per-state outputs:**
  - `T1`: dummy read; `addr_src`=0, `rw`=1.
  - `T2`: push PCH; `addr_src`=1, `pcho`=1, `sp_dec`=1.
  - `T3`: push PCL; `addr_src`=1, `pclo`=1, `sp_dec`=1.
  - `T4`: push status; `addr_src`=1, `psro`=1, `sp_dec`=1, `b_flag`=(kind==BRK).
  - `T5`: `addr_src`=2, `vec_addr`=base, `pcli`=1, `set_i`=1.
  - `T6`: `addr_src`=2, `vec_addr`=base+1, `pchi`=1; the next state is `IDLE`.
- **RW in T2–T4.** `rw`=0 in `T2`–`T4` except for RST, which keeps `rw`=1. RST still pulses `sp_dec` and the drive enables, giving three phantom reads.
- **Vector base.**
  - RST uses `VEC_RST`. NMI uses `VEC_NMI`. IRQ and BRK use `VEC_IRQ`.
  - Hijack rule: an IRQ or BRK sequence with the NMI latch set at the `T4`→`T5` edge uses `VEC_NMI`. It changes `int_kind` to NMI and clears the latch. `b_flag` was already pushed with its original value.
  - The base is registered at `T4`→`T5` and held through `T6`.

## Timing
- **Latency.** A start condition sampled at edge N gives `T1` during cycle N+1. `busy` falls on the edge after `T6`.
- **Sequence length.** Each sequence is 6 cycles when `RDY`=1.
- **RDY stall.**
  - With `RDY`=0 in a state where `rw`=1, the state holds and all outputs hold.
  - `pcli`, `pchi`, `sp_dec` and `set_i` are forced to 0 during the stall, so each fires exactly once, on the cycle `RDY`=1.
  - Write states (`rw`=0) ignore `RDY`.
- **Edge-detect registers.** They sample `NMI` every cycle, including during a stall. Their reset value is 1 (deasserted).

## Structure
- `mos6502_pkg` holds:
  - `seq_state_t` enum
  - `int_kind_t` enum (RST/NMI/IRQ/BRK)
  - `addr_src_t` (PC/STACK/VEC)
  - default vector constants
- One sub-module, `nmi_edge_latch`, containing the registered NMI sample, the falling-edge detect, and the set/clear latch with set priority.
- The state machine and output decode stay in `interrupt_sequencer`, with outputs as a registered state plus combinational decode.

## Test plan
- **Reset.** Hold `RST_N`=0 for 3 cycles, then release. Expect `T1`..`T6` with `rw`=1 on every cycle, `vec_addr` = FFFC then FFFD, `pcli` then `pchi`, and three `sp_dec` pulses. `busy`=0 on the 7th cycle after release.
- **IRQ taken.** `IRQ`=0, `i_flag`=0, `insn_done` pulse. Expect `rw`=0 in `T2`–`T4`, `b_flag`=0, `vec_addr`=FFFE/FFFF, `set_i` in `T5`, `int_kind`=2.
- **IRQ masked, NMI taken.** With `i_flag`=1 and `IRQ`=0, expect `busy` to stay 0. Then drive an `NMI` 1→0 edge and pulse `insn_done`. Expect vector FFFA/FFFB, `int_kind`=1, and the latch cleared at `T5`.
- **NMI hijack of BRK.** `brk_req` pulse, with an NMI falling edge during `T3`. Expect `b_flag`=1 in `T4`, `vec_addr`=FFFA in `T5`, `int_kind`=1, and no second NMI sequence afterwards.
- **RDY stall.** `RDY`=0 for 3 cycles on entering `T5`. Expect the sequence to last 9 cycles, with `pcli` and `set_i` high on exactly one cycle and `vec_addr` held at FFFE.
- **Reset mid-sequence.** `RST_N`=0 during `T3` of an IRQ sequence. Expect `RST_HOLD` on the next cycle with `rw`=1 and all enables 0. After release, a full RST sequence to FFFC runs.

Source files
------------

// File: rtl/mos6502_pkg.sv
// Shared types and default vectors for the tinymos6502 interrupt sequencer.
package mos6502_pkg;

  typedef enum logic [2:0] {
    StRstHold = 3'd0,
    StIdle    = 3'd1,
    StT1      = 3'd2,
    StT2      = 3'd3,
    StT3      = 3'd4,
    StT4      = 3'd5,
    StT5      = 3'd6,
    StT6      = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    KindRst = 2'd0,
    KindNmi = 2'd1,
    KindIrq = 2'd2,
    KindBrk = 2'd3
  } int_kind_t;

  typedef enum logic [1:0] {
    AddrPc    = 2'd0,
    AddrStack = 2'd1,
    AddrVec   = 2'd2
  } addr_src_t;

  localparam logic [15:0] VecNmiDefault = 16'hFFFA;
  localparam logic [15:0] VecRstDefault = 16'hFFFC;
  localparam logic [15:0] VecIrqDefault = 16'hFFFE;

endpackage

// File: rtl/nmi_edge_latch.sv
// Registered NMI falling-edge detector feeding a pending latch; a new edge beats a clear.
module nmi_edge_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic nmi_ni,
  input  logic clr_i,
  output logic pending_o
);

  logic nmi_q;
  logic pend_q;
  logic fall;

  assign fall      = nmi_q & ~nmi_ni;
  assign pending_o = pend_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nmi_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      nmi_q  <= nmi_ni;
      pend_q <= fall | (pend_q & ~clr_i);
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK sequencer: owns the datapath enables for the six-cycle push-and-vector sequence.
module interrupt_sequencer
  import mos6502_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = VecNmiDefault,
  parameter logic [15:0] VEC_RST = VecRstDefault,
  parameter logic [15:0] VEC_IRQ = VecIrqDefault
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RDY,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic        i_flag,
  input  logic        insn_done,
  input  logic        brk_req,
  output logic        busy,
  output logic        rw,
  output logic [1:0]  addr_src,
  output logic [15:0] vec_addr,
  output logic        pcho,
  output logic        pclo,
  output logic        psro,
  output logic        pchi,
  output logic        pcli,
  output logic        sp_dec,
  output logic        b_flag,
  output logic        set_i,
  output logic [1:0]  int_kind
);

  seq_state_t  state_q, state_d;
  int_kind_t   kind_q, kind_d;
  logic [15:0] base_q, base_d;
  logic        nmi_pending;
  logic        nmi_clr;
  logic        hijack;
  logic        in_seq;
  logic        stall;

  nmi_edge_latch u_nmi_edge_latch (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .nmi_ni   (NMI),
    .clr_i    (nmi_clr),
    .pending_o(nmi_pending)
  );

  assign in_seq = (state_q != StRstHold) && (state_q != StIdle);
  assign hijack = ((kind_q == KindIrq) || (kind_q == KindBrk)) && nmi_pending;

  always_comb begin
    busy     = 1'b1;
    rw       = 1'b1;
    addr_src = AddrPc;
    vec_addr = 16'h0000;
    pcho     = 1'b0;
    pclo     = 1'b0;
    psro     = 1'b0;
    pchi     = 1'b0;
    pcli     = 1'b0;
    sp_dec   = 1'b0;
    b_flag   = 1'b0;
    set_i    = 1'b0;
    int_kind = in_seq ? kind_q : KindRst;
    unique case (state_q)
      StRstHold, StT1: ;
      StIdle: busy = 1'b0;
      // Reset keeps reading through the push slots: three phantom reads.
      StT2: begin
        addr_src = AddrStack;
        pcho     = 1'b1;
        sp_dec   = 1'b1;
        rw       = (kind_q == KindRst);
      end
      StT3: begin
        addr_src = AddrStack;
        pclo     = 1'b1;
        sp_dec   = 1'b1;
        rw       = (kind_q == KindRst);
      end
      StT4: begin
        addr_src = AddrStack;
        psro     = 1'b1;
        sp_dec   = 1'b1;
        b_flag   = (kind_q == KindBrk);
        rw       = (kind_q == KindRst);
      end
      StT5: begin
        addr_src = AddrVec;
        vec_addr = base_q;
        pcli     = 1'b1;
        set_i    = 1'b1;
      end
      StT6: begin
        addr_src = AddrVec;
        vec_addr = base_q + 16'd1;
        pchi     = 1'b1;
      end
    endcase
    // Side-effecting strobes must fire once, on the cycle the read completes.
    stall = in_seq && rw && !RDY;
    if (stall) begin
      pcli   = 1'b0;
      pchi   = 1'b0;
      sp_dec = 1'b0;
      set_i  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    base_d  = base_q;
    nmi_clr = 1'b0;
    unique case (state_q)
      StRstHold: begin
        state_d = StT1;
        kind_d  = KindRst;
      end
      StIdle: begin
        if (nmi_pending && insn_done) begin
          state_d = StT1;
          kind_d  = KindNmi;
        end else if (brk_req) begin
          state_d = StT1;
          kind_d  = KindBrk;
        end else if (insn_done && !IRQ && !i_flag) begin
          state_d = StT1;
          kind_d  = KindIrq;
        end
      end
      StT1: if (!stall) state_d = StT2;
      StT2: if (!stall) state_d = StT3;
      StT3: if (!stall) state_d = StT4;
      StT4: begin
        if (!stall) begin
          state_d = StT5;
          unique case (kind_q)
            KindRst: base_d = VEC_RST;
            KindNmi: base_d = VEC_NMI;
            KindIrq, KindBrk: base_d = VEC_IRQ;
          endcase
          if (hijack) begin
            kind_d = KindNmi;
            base_d = VEC_NMI;
          end
          nmi_clr = (kind_q == KindNmi) || hijack;
        end
      end
      StT5: if (!stall) state_d = StT6;
      StT6: if (!stall) state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= StRstHold;
      kind_q  <= KindRst;
      base_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Table-driven bench for interrupt_sequencer plus hand-written latency/priority sequences.
module tb_interrupt_sequencer;

  localparam int SHold = 0;
  localparam int SIdle = 7;

  logic        CLK = 1'b0;
  logic        RST_N, RDY, IRQ, NMI, i_flag, insn_done, brk_req;
  logic        busy, rw, pcho, pclo, psro, pchi, pcli, sp_dec, b_flag, set_i;
  logic [1:0]  addr_src, int_kind;
  logic [15:0] vec_addr;

  typedef struct packed {
    logic        busy;
    logic        rw;
    logic [1:0]  addr_src;
    logic [15:0] vec_addr;
    logic        pcho;
    logic        pclo;
    logic        psro;
    logic        pchi;
    logic        pcli;
    logic        sp_dec;
    logic        b_flag;
    logic        set_i;
    logic [1:0]  int_kind;
  } exp_t;

  typedef struct {
    logic rst_n, rdy, irq, nmi, ifl, idn, brk;
    exp_t exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  interrupt_sequencer dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RDY      (RDY),
    .IRQ      (IRQ),
    .NMI      (NMI),
    .i_flag   (i_flag),
    .insn_done(insn_done),
    .brk_req  (brk_req),
    .busy     (busy),
    .rw       (rw),
    .addr_src (addr_src),
    .vec_addr (vec_addr),
    .pcho     (pcho),
    .pclo     (pclo),
    .psro     (psro),
    .pchi     (pchi),
    .pcli     (pcli),
    .sp_dec   (sp_dec),
    .b_flag   (b_flag),
    .set_i    (set_i),
    .int_kind (int_kind)
  );

  always #5 CLK = ~CLK;

  // Expected outputs for a state: st 0 = RST_HOLD, 1..6 = T1..T6, 7 = IDLE.
  function automatic exp_t model(input int st, input logic [1:0] k, input logic [15:0] base,
                                 input logic rdy);
    exp_t e;
    e      = '0;
    e.rw   = 1'b1;
    e.busy = (st != SIdle);
    if (st >= 1 && st <= 6) e.int_kind = k;
    case (st)
      2: begin e.addr_src = 2'd1; e.pcho = 1'b1; e.sp_dec = 1'b1; e.rw = (k == 2'd0); end
      3: begin e.addr_src = 2'd1; e.pclo = 1'b1; e.sp_dec = 1'b1; e.rw = (k == 2'd0); end
      4: begin
        e.addr_src = 2'd1; e.psro = 1'b1; e.sp_dec = 1'b1; e.rw = (k == 2'd0);
        e.b_flag   = (k == 2'd3);
      end
      5: begin e.addr_src = 2'd2; e.vec_addr = base; e.pcli = 1'b1; e.set_i = 1'b1; end
      6: begin e.addr_src = 2'd2; e.vec_addr = base + 16'd1; e.pchi = 1'b1; end
      default: ;
    endcase
    if (st >= 1 && st <= 6 && e.rw && !rdy) begin
      e.pcli = 1'b0; e.pchi = 1'b0; e.sp_dec = 1'b0; e.set_i = 1'b0;
    end
    return e;
  endfunction

  task automatic add(input logic r, input logic rdy, input logic irq, input logic nmi,
                     input logic ifl, input logic idn, input logic brk,
                     input int st, input logic [1:0] k, input logic [15:0] base);
    vec_t v;
    v.rst_n = r; v.rdy = rdy; v.irq = irq; v.nmi = nmi;
    v.ifl = ifl; v.idn = idn; v.brk = brk;
    v.exp = model(st, k, base, rdy);
    vecs.push_back(v);
  endtask

  task automatic add_run(input logic [1:0] k, input logic [15:0] base, input int from,
                         input int to);
    for (int s = from; s <= to; s++) add(1, 1, 1, 1, 0, 0, 0, s, k, base);
  endtask

  task automatic add_idle();
    add(1, 1, 1, 1, 0, 0, 0, SIdle, 2'd0, 16'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t act;
    int   lat;
    int   len;

    RST_N = 1'b0; RDY = 1'b1; IRQ = 1'b1; NMI = 1'b1;
    i_flag = 1'b0; insn_done = 1'b0; brk_req = 1'b0;

    // Reset held, then full RST sequence with three phantom reads.
    add(0, 1, 1, 1, 0, 0, 0, SHold, 2'd0, 16'h0);
    add(0, 1, 1, 1, 0, 0, 0, SHold, 2'd0, 16'h0);
    add(1, 1, 1, 1, 0, 0, 0, SHold, 2'd0, 16'h0);
    add_run(2'd0, 16'hFFFC, 1, 6);
    add_idle();
    // IRQ taken.
    add(1, 1, 0, 1, 0, 1, 0, SIdle, 2'd0, 16'h0);
    add_run(2'd2, 16'hFFFE, 1, 6);
    add_idle();
    // IRQ masked, then NMI edge taken; latch must be gone afterwards.
    add(1, 1, 0, 1, 1, 1, 0, SIdle, 2'd0, 16'h0);
    add(1, 1, 0, 1, 1, 1, 0, SIdle, 2'd0, 16'h0);
    add(1, 1, 1, 0, 1, 0, 0, SIdle, 2'd0, 16'h0);
    add(1, 1, 0, 0, 1, 1, 0, SIdle, 2'd0, 16'h0);
    add_run(2'd1, 16'hFFFA, 1, 6);
    add(1, 1, 0, 1, 1, 1, 0, SIdle, 2'd0, 16'h0);
    add(1, 1, 0, 1, 1, 1, 0, SIdle, 2'd0, 16'h0);
    // BRK hijacked by an NMI edge during T3.
    add(1, 1, 1, 1, 0, 0, 1, SIdle, 2'd0, 16'h0);
    add_run(2'd3, 16'hFFFE, 1, 2);
    add(1, 1, 1, 0, 0, 0, 0, 3, 2'd3, 16'h0);
    add(1, 1, 1, 0, 0, 0, 0, 4, 2'd3, 16'h0);
    add_run(2'd1, 16'hFFFA, 5, 6);
    add(1, 1, 1, 1, 0, 1, 0, SIdle, 2'd0, 16'h0);
    add(1, 1, 1, 1, 0, 1, 0, SIdle, 2'd0, 16'h0);
    // RDY stall for three cycles on entering T5.
    add(1, 1, 0, 1, 0, 1, 0, SIdle, 2'd0, 16'h0);
    add_run(2'd2, 16'hFFFE, 1, 4);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 0, 0, 0, 5, 2'd2, 16'hFFFE);
    add_run(2'd2, 16'hFFFE, 5, 6);
    add_idle();
    // Reset mid-sequence, then RST with a stalled phantom read in T3.
    add(1, 1, 0, 1, 0, 1, 0, SIdle, 2'd0, 16'h0);
    add_run(2'd2, 16'hFFFE, 1, 2);
    add(0, 1, 1, 1, 0, 0, 0, 3, 2'd2, 16'hFFFE);
    add(1, 1, 1, 1, 0, 0, 0, SHold, 2'd0, 16'h0);
    add_run(2'd0, 16'hFFFC, 1, 2);
    add(1, 0, 1, 1, 0, 0, 0, 3, 2'd0, 16'hFFFC);
    add_run(2'd0, 16'hFFFC, 3, 6);
    add_idle();

    @(posedge CLK);
    foreach (vecs[i]) begin
      @(posedge CLK); #1;
      RST_N = vecs[i].rst_n; RDY = vecs[i].rdy; IRQ = vecs[i].irq; NMI = vecs[i].nmi;
      i_flag = vecs[i].ifl; insn_done = vecs[i].idn; brk_req = vecs[i].brk;
      @(negedge CLK);
      act = {busy, rw, addr_src, vec_addr, pcho, pclo, psro, pchi, pcli, sp_dec,
             b_flag, set_i, int_kind};
      chk($sformatf("vec%0d", i), {2'b00, act}, {2'b00, vecs[i].exp});
    end

    // NMI: T1 the cycle after the start edge, six busy cycles.
    @(posedge CLK); #1;
    RST_N = 1'b1; RDY = 1'b1; IRQ = 1'b1; NMI = 1'b1;
    i_flag = 1'b0; insn_done = 1'b0; brk_req = 1'b0;
    @(posedge CLK); #1; NMI = 1'b0;
    @(posedge CLK); #1; insn_done = 1'b1;
    @(posedge CLK); #1; insn_done = 1'b0;
    @(negedge CLK);
    lat = 0;
    while (!busy && lat < 4) begin @(negedge CLK); lat++; end
    chk("nmi_start_latency", lat, 0);
    chk("nmi_kind_t1", {30'd0, int_kind}, 32'd1);
    len = 0;
    while (busy && len < 20) begin len++; @(negedge CLK); end
    chk("nmi_seq_len", len, 6);

    // BRK outranks a simultaneous unmasked IRQ.
    @(posedge CLK); #1;
    NMI = 1'b1; IRQ = 1'b0; insn_done = 1'b1; brk_req = 1'b1;
    @(posedge CLK); #1;
    IRQ = 1'b1; insn_done = 1'b0; brk_req = 1'b0;
    @(negedge CLK);
    chk("brk_prio_busy", {31'd0, busy}, 32'd1);
    chk("brk_prio_kind", {30'd0, int_kind}, 32'd3);
    len = 0;
    while (busy && len < 20) begin len++; @(negedge CLK); end
    chk("brk_seq_len", len, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
